// File: rtl/game_tick_scheduler_pkg.sv
// Shared types for the game tick scheduler.
// FSM state encoding and mode values.
package game_tick_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TICK = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

  localparam logic MODE_AUTO = 1'b0;
  localparam logic MODE_STEP = 1'b1;

endpackage

// File: rtl/game_tick_scheduler_key_debouncer.sv
// Step-key synchronizer and debouncer.
// Emits one pulse per accepted press.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_in,
  output logic press_out
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic          db;
  logic [CW-1:0] cnt;
  logic          stable_hit;

  assign stable_hit = (cnt == CW'(DEBOUNCE_CYCLES - 1));

  // Key is active-low, so idle/released state is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync      <= 2'b11;
      db        <= 1'b1;
      cnt       <= '0;
      press_out <= 1'b0;
    end else begin
      sync      <= {sync[0], key_n_in};
      press_out <= 1'b0;
      if (sync[1] == db) begin
        cnt <= '0;
      end else if (stable_hit) begin
        db        <= sync[1];
        cnt       <= '0;
        press_out <= ~sync[1];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/game_tick_scheduler.sv
// Frame/key driven tick-enable scheduler with
// tick/done handshake, overrun and timeout status.
module game_tick_scheduler
  import game_tick_scheduler_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TIMEOUT_CYCLES  = 833_334,
  parameter int CNT_W           = 16
) (
  input  logic             clk_50Mhz_in,
  input  logic             reset_n_in,
  input  logic             sw1_in,
  input  logic             key_step_in,
  input  logic             frame_sync_in,
  input  logic             logic_done_in,
  input  logic             clear_status_in,
  output logic             tick_out,
  output logic             busy_out,
  output logic             mode_out,
  output logic [CNT_W-1:0] tick_count_out,
  output logic [CNT_W-1:0] overrun_count_out,
  output logic             overrun_out,
  output logic             timeout_out
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state, state_nx;
  logic [1:0]    sw_sync, fr_sync;
  logic          fr_prev;
  logic          key_press;
  logic          pending;
  logic [TW-1:0] timer;
  logic          frame_evt, evt, mode_chg, drop;
  logic          tmr_hit, timeout_hit;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clk      (clk_50Mhz_in),
    .rst_n    (reset_n_in),
    .key_n_in (key_step_in),
    .press_out(key_press)
  );

  assign frame_evt   = fr_sync[1] & ~fr_prev;
  assign evt         = (mode_out == MODE_AUTO) ? frame_evt : key_press;
  assign mode_chg    = (state == ST_IDLE) && (sw_sync[1] != mode_out);
  // The TICK cycle clears pending, so an event there is not a drop.
  assign drop        = evt && pending && !mode_chg && (state != ST_TICK);
  assign tmr_hit     = (timer == TW'(TIMEOUT_CYCLES - 1));
  assign timeout_hit = (state == ST_BUSY) && !logic_done_in && tmr_hit;

  always_comb begin
    state_nx = state;
    tick_out = 1'b0;
    busy_out = 1'b0;
    unique case (state)
      ST_IDLE: if (pending && !mode_chg) state_nx = ST_TICK;
      ST_TICK: begin
        tick_out = 1'b1;
        busy_out = 1'b1;
        state_nx = ST_BUSY;
      end
      ST_BUSY: begin
        busy_out = 1'b1;
        if (logic_done_in || tmr_hit) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_50Mhz_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk_50Mhz_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      sw_sync        <= '0;
      fr_sync        <= '0;
      fr_prev        <= 1'b0;
      mode_out       <= MODE_AUTO;
      pending        <= 1'b0;
      timer          <= '0;
      tick_count_out <= '0;
    end else begin
      sw_sync <= {sw_sync[0], sw1_in};
      fr_sync <= {fr_sync[0], frame_sync_in};
      fr_prev <= fr_sync[1];
      if (mode_chg) begin
        mode_out <= sw_sync[1];
        pending  <= 1'b0;
      end else if (evt) begin
        pending <= 1'b1;
      end else if (state == ST_TICK) begin
        pending <= 1'b0;
      end
      if (state == ST_TICK) begin
        timer          <= '0;
        tick_count_out <= tick_count_out + CNT_W'(1);
      end else if (state == ST_BUSY) begin
        timer <= timer + TW'(1);
      end
    end
  end

  always_ff @(posedge clk_50Mhz_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      overrun_out       <= 1'b0;
      overrun_count_out <= '0;
      timeout_out       <= 1'b0;
    end else begin
      if (drop) begin
        overrun_out <= 1'b1;
        if (clear_status_in)
          overrun_count_out <= CNT_W'(1);
        else if (!(&overrun_count_out))
          overrun_count_out <= overrun_count_out + CNT_W'(1);
      end else if (clear_status_in) begin
        overrun_out       <= 1'b0;
        overrun_count_out <= '0;
      end
      if (timeout_hit)
        timeout_out <= 1'b1;
      else if (clear_status_in)
        timeout_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Randomized scoreboard bench for game_tick_scheduler
// against a behavioural reference model.
module tb_game_tick_scheduler;

  localparam int DB = 8;
  localparam int TO = 20;
  localparam int CW = 16;
  localparam int P_IDLE = 0;
  localparam int P_TICK = 1;
  localparam int P_BUSY = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sw1 = 1'b0, key = 1'b1, frame = 1'b0;
  logic done = 1'b0, clr = 1'b0;
  logic tick_out, busy_out, mode_out, overrun_out, timeout_out;
  logic [CW-1:0] tick_count_out, overrun_count_out;

  always #5 clk = ~clk;

  game_tick_scheduler #(
    .DEBOUNCE_CYCLES(DB),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (CW)
  ) dut (
    .clk_50Mhz_in     (clk),
    .reset_n_in       (rst_n),
    .sw1_in           (sw1),
    .key_step_in      (key),
    .frame_sync_in    (frame),
    .logic_done_in    (done),
    .clear_status_in  (clr),
    .tick_out         (tick_out),
    .busy_out         (busy_out),
    .mode_out         (mode_out),
    .tick_count_out   (tick_count_out),
    .overrun_count_out(overrun_count_out),
    .overrun_out      (overrun_out),
    .timeout_out      (timeout_out)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               name, act, exp_v, $time);
    end
  endtask

  // Reference model: inputs seen through a 2-sample delay,
  // debounce as "run of identical samples", phase-level handshake.
  typedef struct {
    int edge_n;
    int tcnt;
    int ocnt;
  } exp_t;
  exp_t q[$];

  int   ecount = 0;
  logic sh[3], fh[3], kh[3];
  logic klast, kdb, kpress;
  int   krun;
  int   phase, bcyc, m_tcnt, m_ocnt;
  logic m_mode, m_pend, m_ovr, m_tmo;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      sh[i] = 1'b0;
      fh[i] = 1'b0;
      kh[i] = 1'b1;
    end
    klast = 1'b1; kdb = 1'b1; kpress = 1'b0; krun = 0;
    phase = P_IDLE; bcyc = 0; m_tcnt = 0; m_ocnt = 0;
    m_mode = 1'b0; m_pend = 1'b0; m_ovr = 1'b0; m_tmo = 1'b0;
    q.delete();
  endtask

  task automatic model_step();
    logic fr_evt, pr_evt, evt, kv, drop, tmo_now;
    fr_evt = fh[1] && !fh[2];
    pr_evt = kpress;
    kpress = 1'b0;
    kv = kh[1];
    if (kv == klast) krun++;
    else begin
      klast = kv;
      krun = 1;
    end
    if (kv != kdb && krun == DB) begin
      kdb = kv;
      kpress = !kv;
    end
    evt = m_mode ? pr_evt : fr_evt;
    drop = 1'b0;
    tmo_now = 1'b0;
    case (phase)
      P_IDLE: begin
        if (sh[1] != m_mode) begin
          m_mode = sh[1];
          m_pend = 1'b0;
        end else if (m_pend) begin
          phase = P_TICK;
          drop = evt;
        end else if (evt) begin
          m_pend = 1'b1;
        end
      end
      P_TICK: begin
        m_tcnt++;
        m_pend = evt;
        phase = P_BUSY;
        bcyc = 0;
      end
      default: begin
        if (evt) begin
          if (m_pend) drop = 1'b1;
          else m_pend = 1'b1;
        end
        bcyc++;
        if (done) phase = P_IDLE;
        else if (bcyc == TO) begin
          phase = P_IDLE;
          tmo_now = 1'b1;
        end
      end
    endcase
    if (drop) begin
      m_ovr = 1'b1;
      m_ocnt = clr ? 1 : (m_ocnt < 65535 ? m_ocnt + 1 : m_ocnt);
    end else if (clr) begin
      m_ovr = 1'b0;
      m_ocnt = 0;
    end
    if (tmo_now) m_tmo = 1'b1;
    else if (clr) m_tmo = 1'b0;
    for (int i = 2; i > 0; i--) begin
      sh[i] = sh[i-1];
      fh[i] = fh[i-1];
      kh[i] = kh[i-1];
    end
    sh[0] = sw1;
    fh[0] = frame;
    kh[0] = key;
    ecount++;
    if (phase == P_TICK) q.push_back('{ecount, m_tcnt, m_ocnt});
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Monitor: per-cycle status plus scoreboard pop on each tick.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      check("status",
            {tick_out, busy_out, mode_out, overrun_out, timeout_out,
             tick_count_out, overrun_count_out},
            {phase == P_TICK, phase != P_IDLE, m_mode, m_ovr, m_tmo,
             CW'(m_tcnt), CW'(m_ocnt)});
      if (tick_out) begin
        check("tick_queued", q.size() != 0, 1'b1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("tick_edge", ecount, e.edge_n);
          check("tick_counts", {tick_count_out, overrun_count_out},
                {CW'(e.tcnt), CW'(e.ocnt)});
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  int fleft = 0;
  int kleft = 0;

  task automatic run_random(input int n, input int sw_mode,
                            input int done_div, input bit clr_en);
    for (int i = 0; i < n; i++) begin
      cycle();
      if (fleft == 0) begin
        frame = !frame;
        fleft = $urandom_range(0, 25);
      end else fleft--;
      if (kleft == 0) begin
        key = !key;
        kleft = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5)
                                            : $urandom_range(6, 60);
      end else kleft--;
      done = (done_div != 0) && ($urandom_range(0, done_div - 1) == 0);
      clr = clr_en && ($urandom_range(0, 60) == 0);
      if (sw_mode == 2) begin
        if ($urandom_range(0, 80) == 0) sw1 = !sw1;
      end else sw1 = (sw_mode == 1);
    end
    done = 1'b0;
    clr = 1'b0;
  endtask

  task automatic wait_tick(input string name, input int budget,
                           input int k, input int lat);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (tick_out) begin
        seen = 1'b1;
        if (lat >= 0) check(name, ecount - k, lat);
      end
    end
    check({name, "_seen"}, seen, 1'b1);
  endtask

  initial begin
    int k;
    int nticks;
    rst_n = 1'b0;
    repeat (3) cycle();
    check("reset_state",
          {tick_out, busy_out, mode_out, overrun_out, timeout_out,
           tick_count_out, overrun_count_out}, '0);
    rst_n = 1'b1;
    repeat (3) cycle();

    frame = 1'b1;
    k = ecount + 1;
    wait_tick("latency", 10, k, 3);
    repeat (5) cycle();
    done = 1'b1;
    cycle();
    done = 1'b0;
    repeat (4) cycle();
    check("busy_cleared", busy_out, 1'b0);
    check("tick_count_one", tick_count_out, 1);

    run_random(900, 0, 8, 1'b1);
    run_random(900, 1, 8, 1'b1);
    run_random(900, 2, 6, 1'b1);
    run_random(300, 0, 0, 1'b0);
    check("timeout_sticky", timeout_out, 1'b1);

    sw1 = 1'b0;
    done = 1'b1;
    repeat (6) cycle();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    cycle();
    done = 1'b0;
    @(negedge clk);
    check("status_cleared",
          {overrun_out, timeout_out, overrun_count_out}, '0);

    frame = 1'b0;
    key = 1'b1;
    done = 1'b1;
    repeat (30) cycle();
    done = 1'b0;
    cycle();
    frame = 1'b1;
    wait_tick("pre_reset_tick", 12, 0, -1);
    cycle();
    frame = 1'b0;
    repeat (3) cycle();
    frame = 1'b1;
    repeat (5) cycle();
    check("busy_before_reset", busy_out, 1'b1);
    rst_n = 1'b0;
    frame = 1'b0;
    #1;
    check("async_reset",
          {tick_out, busy_out, mode_out, overrun_out, timeout_out,
           tick_count_out, overrun_count_out}, '0);
    repeat (3) cycle();
    rst_n = 1'b1;
    nticks = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tick_out) nticks++;
    end
    check("no_tick_after_reset", nticks, 0);

    run_random(400, 2, 5, 1'b1);
    frame = 1'b0;
    done = 1'b1;
    repeat (40) cycle();
    done = 1'b0;
    @(negedge clk);
    check("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
